// File: rtl/hall_speed_meter.sv
// Hall-sensor front end: synchronise, deglitch, validate commutation order, and average step periods.
// Optional HALL_STEP_COUNT_EN adds a signed 16-bit position counter.
module hall_speed_meter #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       hall_effect,
  output logic             step_pulse,
  output logic             direction,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled,
  output logic             hall_fault
`ifdef HALL_STEP_COUNT_EN
  ,
  output logic signed [15:0] position
`endif
);

  localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
  localparam int unsigned FC_W  = $clog2(FILT_LEN + 1);
  localparam int unsigned SC_W  = AVG_LOG2 + 1;
  localparam int unsigned AVG_N = 1 << AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       CODE_RST = 3'b101;

  // Position of a code in the forward commutation cycle; 7 marks an illegal code.
  function automatic logic [2:0] code_idx(input logic [2:0] code);
    case (code)
      3'b101:  code_idx = 3'd0;
      3'b100:  code_idx = 3'd1;
      3'b110:  code_idx = 3'd2;
      3'b010:  code_idx = 3'd3;
      3'b011:  code_idx = 3'd4;
      3'b001:  code_idx = 3'd5;
      default: code_idx = 3'd7;
    endcase
  endfunction

  logic [2:0]      r_sync1, r_sync2, r_cand;
  logic [FC_W-1:0] r_fcnt;
  logic            r_acc_stb, r_ev_stb;
  logic [2:0]      r_acc_code, r_ev_code;

  logic            w_change, w_accept;
  logic [FC_W-1:0] w_fcnt_nxt;

  assign w_change   = (r_sync2 != r_cand);
  assign w_fcnt_nxt = w_change ? FC_W'(1)
                    : ((r_fcnt < FC_W'(FILT_LEN)) ? r_fcnt + FC_W'(1) : r_fcnt);
  assign w_accept   = (w_fcnt_nxt == FC_W'(FILT_LEN)) && (w_change || (r_fcnt != FC_W'(FILT_LEN)));

  // Synchroniser, run-length filter, and two-stage accepted-code pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1    <= CODE_RST;
      r_sync2    <= CODE_RST;
      r_cand     <= CODE_RST;
      r_fcnt     <= '0;
      r_acc_stb  <= 1'b0;
      r_acc_code <= CODE_RST;
      r_ev_stb   <= 1'b0;
      r_ev_code  <= CODE_RST;
    end else begin
      r_sync1    <= hall_effect;
      r_sync2    <= r_sync1;
      r_cand     <= r_sync2;
      r_fcnt     <= w_fcnt_nxt;
      r_acc_stb  <= w_accept;
      r_acc_code <= r_sync2;
      r_ev_stb   <= r_acc_stb;
      r_ev_code  <= r_acc_code;
    end
  end

  logic [2:0]       r_stored;
  logic             r_dir, r_step, r_fault, r_pv, r_stalled, r_armed;
  logic [CNT_W-1:0] r_period, r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [SC_W-1:0]  r_scnt;

  logic [2:0]       w_old_idx, w_new_idx, w_fwd_idx, w_rev_idx;
  logic             w_illegal, w_same, w_fwd, w_rev, w_step, w_skip, w_bad;
  logic [CNT_W-1:0] w_sample;
  logic [ACC_W-1:0] w_acc_sum;
  logic [SC_W-1:0]  w_scnt_sum;

  assign w_old_idx  = code_idx(r_stored);
  assign w_new_idx  = code_idx(r_ev_code);
  assign w_fwd_idx  = (w_old_idx == 3'd5) ? 3'd0 : w_old_idx + 3'd1;
  assign w_rev_idx  = (w_old_idx == 3'd0) ? 3'd5 : w_old_idx - 3'd1;
  assign w_illegal  = (w_new_idx == 3'd7);
  assign w_same     = (r_ev_code == r_stored);
  assign w_fwd      = (w_new_idx == w_fwd_idx);
  assign w_rev      = (w_new_idx == w_rev_idx);
  assign w_step     = r_ev_stb && !w_illegal && !w_same && (w_fwd || w_rev);
  assign w_skip     = r_ev_stb && !w_illegal && !w_same && !w_fwd && !w_rev;
  assign w_bad      = r_ev_stb && w_illegal;
  // The counter is cleared on the step edge, so clocks between steps is its value plus one.
  assign w_sample   = r_cnt + CNT_W'(1);
  assign w_acc_sum  = r_acc + ACC_W'(w_sample);
  assign w_scnt_sum = r_scnt + SC_W'(1);

  logic [2:0]       w_stored_nxt;
  logic             w_dir_nxt, w_step_nxt, w_fault_nxt, w_pv_nxt, w_stalled_nxt, w_armed_nxt;
  logic [CNT_W-1:0] w_period_nxt, w_cnt_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [SC_W-1:0]  w_scnt_nxt;

  // Step classification, period measurement and stall detection.
  always_comb begin
    w_stored_nxt  = r_stored;
    w_dir_nxt     = r_dir;
    w_step_nxt    = w_step;
    w_fault_nxt   = w_bad || w_skip;
    w_pv_nxt      = 1'b0;
    w_stalled_nxt = r_stalled;
    w_armed_nxt   = r_armed;
    w_period_nxt  = r_period;
    w_cnt_nxt     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    w_acc_nxt     = r_acc;
    w_scnt_nxt    = r_scnt;

    if (w_step) begin
      w_stored_nxt  = r_ev_code;
      w_dir_nxt     = w_fwd;
      w_cnt_nxt     = '0;
      w_stalled_nxt = 1'b0;
      w_armed_nxt   = 1'b1;
      if (r_armed && (r_cnt != CNT_MAX)) begin
        if (w_scnt_sum == SC_W'(AVG_N)) begin
          w_period_nxt = CNT_W'(w_acc_sum >> AVG_LOG2);
          w_pv_nxt     = 1'b1;
          w_acc_nxt    = '0;
          w_scnt_nxt   = '0;
        end else begin
          w_acc_nxt  = w_acc_sum;
          w_scnt_nxt = w_scnt_sum;
        end
      end
    end else if (w_skip) begin
      w_stored_nxt = r_ev_code;
      w_armed_nxt  = 1'b0;
      w_acc_nxt    = '0;
      w_scnt_nxt   = '0;
    end

    if (!w_step && (r_cnt == CNT_MAX)) begin
      w_stalled_nxt = 1'b1;
      w_armed_nxt   = 1'b0;
      w_acc_nxt     = '0;
      w_scnt_nxt    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stored  <= CODE_RST;
      r_dir     <= 1'b1;
      r_step    <= 1'b0;
      r_fault   <= 1'b0;
      r_pv      <= 1'b0;
      r_stalled <= 1'b1;
      r_armed   <= 1'b0;
      r_period  <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_scnt    <= '0;
    end else begin
      r_stored  <= w_stored_nxt;
      r_dir     <= w_dir_nxt;
      r_step    <= w_step_nxt;
      r_fault   <= w_fault_nxt;
      r_pv      <= w_pv_nxt;
      r_stalled <= w_stalled_nxt;
      r_armed   <= w_armed_nxt;
      r_period  <= w_period_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_scnt    <= w_scnt_nxt;
    end
  end

  assign step_pulse   = r_step;
  assign direction    = r_dir;
  assign period       = r_period;
  assign period_valid = r_pv;
  assign stalled      = r_stalled;
  assign hall_fault   = r_fault;

`ifdef HALL_STEP_COUNT_EN
  logic [15:0] r_pos;

  // Signed step count, wrapping in two's complement.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pos <= '0;
    end else if (w_step) begin
      r_pos <= w_fwd ? r_pos + 16'd1 : r_pos - 16'd1;
    end
  end

  assign position = r_pos;
`endif

endmodule
